// File: rtl/pt5_lane_unpacker.sv
// PT-5 lane unpacker: decodes packed base-3 bytes into per-lane trits and
// tracks frame depth beats through a two-entry output buffer.
module pt5_lane_unpacker #(
  parameter int LANE_COUNT = 15,
  localparam int BYTES = LANE_COUNT / 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic [15:0]             frame_depth,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*BYTES-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*LANE_COUNT-1:0] out_trits,
  output logic                    out_last,
  output logic                    frame_done,
  output logic                    decode_err,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [15:0] depth_reg;
  logic [15:0] accepted;
  logic [15:0] delivered;

  logic [2*LANE_COUNT-1:0] fifo_data [2];
  logic [1:0]              fifo_last;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              fifo_count;

  logic [2*LANE_COUNT-1:0] decoded;
  logic [BYTES-1:0]        bad_byte;
  logic                    push;
  logic                    pop;
  logic                    push_last;
  logic                    load_frame;
  logic                    done_next;
  logic                    done_reg;
  logic                    err_reg;

  // Five base-3 digits per byte, least significant digit on the lowest lane.
  function automatic logic [9:0] decode_byte(input logic [7:0] v);
    logic [7:0] rem;
    logic [1:0] digit;
    logic [9:0] lanes;
    lanes = '0;
    rem   = v;
    for (int i = 0; i < 5; i++) begin
      digit = 2'(rem % 8'd3);
      rem   = rem / 8'd3;
      case (digit)
        2'd0:    lanes[2*i +: 2] = 2'b10;
        2'd2:    lanes[2*i +: 2] = 2'b01;
        default: lanes[2*i +: 2] = 2'b00;
      endcase
    end
    if (v > 8'd242) begin
      lanes = '0;
    end
    return lanes;
  endfunction

  always_comb begin
    decoded  = '0;
    bad_byte = '0;
    for (int j = 0; j < BYTES; j++) begin
      decoded[10*j +: 10] = decode_byte(in_data[8*j +: 8]);
      bad_byte[j]         = (in_data[8*j +: 8] > 8'd242);
    end
  end

  // Input acceptance looks only at registered state, never at out_ready.
  assign in_ready  = (state == RUN) && (fifo_count < 2'd2) && (accepted < depth_reg);
  assign push      = in_valid && in_ready;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push_last = (accepted == depth_reg - 16'd1);
  assign out_trits = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= decoded;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          if (frame_depth == 16'd0) begin
            done_next = 1'b1;
          end else begin
            load_frame = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (push && push_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last && (delivered == depth_reg - 16'd1)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_reg <= 16'd0;
      accepted  <= 16'd0;
      delivered <= 16'd0;
    end else if (load_frame) begin
      depth_reg <= frame_depth;
      accepted  <= 16'd0;
      delivered <= 16'd0;
    end else begin
      if (push) begin
        accepted <= accepted + 16'd1;
      end
      if (pop) begin
        delivered <= delivered + 16'd1;
      end
    end
  end

  // A new invalid byte outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
      if (push && (bad_byte != '0)) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign frame_done = done_reg;
  assign decode_err = err_reg;

endmodule
